deserializer_fsm: RTL

- Serial-to-parallel stage directly downstream of serializer_fsm in the FIR filter datapath.
- Consumes the LSB-first serial bit stream and its valid/ready handshake.
- Reassembles each LENGTH-bit word and presents it on a parallel valid/ready interface to the next stage (filter input or result checker).

---
 rtl/deserializer_fsm_pkg.sv | 16 +
 rtl/deserializer_fsm.sv | 64 ++++++
 2 files changed

// File: rtl/deserializer_fsm_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package deser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_LENGTH = 24;

    function automatic int unsigned cnt_width(input int unsigned len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/deserializer_fsm.sv
// LSB-first serial-to-parallel stage: collects LENGTH bits, then holds the
// word on a valid/ready interface until downstream takes it.
module deserializer_fsm
    import deser_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready
);

    localparam int unsigned CW = cnt_width(LENGTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [LENGTH-1:0] shreg, shreg_next;
    logic              accept;
    logic              last_bit;

    assign o_ready  = i_rst && i_en && (state != S_HOLD);
    assign accept   = i_en && i_din_valid && o_ready;
    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shreg <= shreg_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        if (accept) begin
            // New bits enter at the MSB so the first bit lands at bit 0.
            shreg_next = {i_din, shreg[LENGTH-1:1]};
            cnt_next   = last_bit ? '0 : cnt + CW'(1);
        end
        unique case (state)
            S_IDLE:  if (accept) state_next = S_SHIFT;
            S_SHIFT: if (accept && last_bit) state_next = S_HOLD;
            S_HOLD:  if (i_en && i_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign o_dout_valid = (state == S_HOLD);
    assign ov_dout      = shreg;

endmodule
